bb_queue_ctrl: RTL and testbench

Pointer and state controller for a 64-entry in-order circular queue of basic blocks. It handles allocation at the tail and in-order retirement at the head. It selects the oldest ready entry for out-of-order issue, using a head-relative mask plus a 64-bit first-one search. On a branch flush it clears every entry younger than the branch. It sits between the front-end allocator and the issue/retire pipeline and owns the queue's valid, ready and issued bit-vectors.

---
 rtl/bb_queue_ctrl.sv | 132 +++++++++++++
 tb/tb_bb_queue_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bb_queue_ctrl.sv
// Purpose: pointer/state controller for a 64-entry in-order basic-block queue with oldest-ready issue select and branch flush.
// Latency: state updates on the clock edge; alloc_ptr/issue_*/retire_ready/count/empty/full are combinational from registered state.
// Backpressure: alloc held off when full or flushing; issue held off when no candidate or flushing; retire held off until head is issued.
module bb_queue_ctrl #(
    parameter int DEPTH = 64,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alloc_valid,
    output logic          alloc_ready,
    output logic [PW-1:0] alloc_ptr,
    input  logic          rdy_set_valid,
    input  logic [PW-1:0] rdy_set_ptr,
    output logic          issue_valid,
    input  logic          issue_ready,
    output logic [PW-1:0] issue_ptr,
    input  logic          retire_valid,
    output logic          retire_ready,
    input  logic          flush_valid,
    input  logic [PW-1:0] flush_ptr,
    output logic [PW-1:0] head_ptr,
    output logic [PW:0]   count,
    output logic          empty,
    output logic          full
);

    logic [PW-1:0]    in_ptr, out_ptr, in_nxt, out_nxt;
    logic [PW:0]      cnt, cnt_nxt;
    logic [DEPTH-1:0] valid, ready, issued;
    logic [DEPTH-1:0] valid_nxt, ready_nxt, issued_nxt;

    logic             alloc_f, issue_f, retire_f;
    logic [DEPTH-1:0] cand, hi_cand, flush_mask;
    logic [PW-1:0]    last;
    logic [PW:0]      flush_sh;
    logic [PW-1:0]    flush_dist;

    localparam logic [DEPTH-1:0] ONES = '1;

    // lowest set bit index; the loop walks downward so the lowest index wins
    function automatic logic [PW-1:0] first_one(input logic [DEPTH-1:0] v);
        first_one = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (v[i]) first_one = PW'(i);
        end
    endfunction

    assign empty        = (cnt == '0);
    assign full         = (cnt == (PW+1)'(DEPTH));
    assign count        = cnt;
    assign head_ptr     = out_ptr;
    assign alloc_ptr    = in_ptr;
    assign alloc_ready  = !full && !flush_valid;
    assign retire_ready = !empty && issued[out_ptr];

    assign alloc_f  = alloc_valid && alloc_ready;
    assign issue_f  = issue_valid && issue_ready;
    assign retire_f = retire_valid && retire_ready;

    // oldest-ready select: entries at or above head are older than wrapped ones below it
    always_comb begin
        cand        = valid & ready & ~issued;
        hi_cand     = cand & (ONES << out_ptr);
        issue_valid = (|cand) && !flush_valid;
        issue_ptr   = (|hi_cand) ? first_one(hi_cand) : first_one(cand);
    end

    // younger-than-branch mask; a 7-bit shift amount lets flush_ptr=63 empty the upper term
    always_comb begin
        last       = in_ptr - PW'(1);
        flush_sh   = {1'b0, flush_ptr} + (PW+1)'(1);
        flush_dist = flush_ptr - out_ptr;
        if (flush_ptr <= last)
            flush_mask = (ONES >> (PW'(DEPTH - 1) - last)) & (ONES << flush_sh);
        else
            flush_mask = (ONES >> (PW'(DEPTH - 1) - last)) | (ONES << flush_sh);
    end

    // next-state for vectors, pointers and occupancy; flush overrides alloc/issue effects
    always_comb begin
        valid_nxt  = valid;
        ready_nxt  = ready;
        issued_nxt = issued;
        if (rdy_set_valid && valid[rdy_set_ptr]) ready_nxt[rdy_set_ptr] = 1'b1;
        if (issue_f) issued_nxt[issue_ptr] = 1'b1;
        if (alloc_f) begin
            valid_nxt[in_ptr]  = 1'b1;
            ready_nxt[in_ptr]  = 1'b0;
            issued_nxt[in_ptr] = 1'b0;
        end
        if (retire_f) begin
            valid_nxt[out_ptr]  = 1'b0;
            ready_nxt[out_ptr]  = 1'b0;
            issued_nxt[out_ptr] = 1'b0;
        end
        if (flush_valid) begin
            valid_nxt  = valid_nxt & ~flush_mask;
            ready_nxt  = ready_nxt & ~flush_mask;
            issued_nxt = issued_nxt & ~flush_mask;
        end

        out_nxt = retire_f ? out_ptr + PW'(1) : out_ptr;
        if (flush_valid) begin
            in_nxt  = flush_sh[PW-1:0];
            cnt_nxt = {1'b0, flush_dist} + (PW+1)'(1) - {{PW{1'b0}}, retire_f};
        end else begin
            in_nxt  = alloc_f ? in_ptr + PW'(1) : in_ptr;
            cnt_nxt = cnt + {{PW{1'b0}}, alloc_f} - {{PW{1'b0}}, retire_f};
        end
    end

    // state register with synchronous reset discarding all entries
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ptr  <= '0;
            out_ptr <= '0;
            cnt     <= '0;
            valid   <= '0;
            ready   <= '0;
            issued  <= '0;
        end else begin
            in_ptr  <= in_nxt;
            out_ptr <= out_nxt;
            cnt     <= cnt_nxt;
            valid   <= valid_nxt;
            ready   <= ready_nxt;
            issued  <= issued_nxt;
        end
    end

endmodule

// File: tb/tb_bb_queue_ctrl.sv
// Purpose: directed self-checking bench for bb_queue_ctrl.
// Latency: inputs driven 1ns after the rising edge, outputs sampled in the same window.
// Backpressure: issue/retire/alloc handshakes driven explicitly per scenario.
module tb_bb_queue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_valid, alloc_ready;
    logic [5:0]  alloc_ptr;
    logic        rdy_set_valid;
    logic [5:0]  rdy_set_ptr;
    logic        issue_valid, issue_ready;
    logic [5:0]  issue_ptr;
    logic        retire_valid, retire_ready;
    logic        flush_valid;
    logic [5:0]  flush_ptr;
    logic [5:0]  head_ptr;
    logic [6:0]  count;
    logic        empty, full;

    int errors = 0;
    int checks = 0;

    bb_queue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_ptr(alloc_ptr),
        .rdy_set_valid(rdy_set_valid), .rdy_set_ptr(rdy_set_ptr),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_ptr(issue_ptr),
        .retire_valid(retire_valid), .retire_ready(retire_ready),
        .flush_valid(flush_valid), .flush_ptr(flush_ptr),
        .head_ptr(head_ptr), .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 0; rdy_set_valid = 0; rdy_set_ptr = '0; issue_ready = 0;
        retire_valid = 0; flush_valid = 0; flush_ptr = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0; step(); rst_n = 1; #1;
    endtask

    task automatic alloc_n(input int n);
        alloc_valid = 1;
        for (int i = 0; i < n; i++) step();
        alloc_valid = 0; #1;
    endtask

    task automatic set_ready(input logic [5:0] p);
        rdy_set_valid = 1; rdy_set_ptr = p; step(); rdy_set_valid = 0; #1;
    endtask

    // from empty at slot 0: allocate, ready, issue and retire n entries so head lands on n
    task automatic advance_head(input int n);
        alloc_n(n);
        issue_ready = 1; retire_valid = 1;
        for (int k = 0; k < n; k++) begin
            rdy_set_valid = 1; rdy_set_ptr = 6'(k); step();
        end
        rdy_set_valid = 0;
        for (int k = 0; k < 3; k++) step();
        idle(); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL rst_alloc_ready got=%b exp=1", alloc_ready); end
        checks++; if (alloc_ptr !== 6'd0) begin errors++; $display("FAIL rst_alloc_ptr got=%0d exp=0", alloc_ptr); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL rst_issue_valid got=%b exp=0", issue_valid); end
        checks++; if (issue_ptr !== 6'd0) begin errors++; $display("FAIL rst_issue_ptr got=%0d exp=0", issue_ptr); end
        checks++; if (retire_ready !== 1'b0) begin errors++; $display("FAIL rst_retire_ready got=%b exp=0", retire_ready); end
        checks++; if (head_ptr !== 6'd0) begin errors++; $display("FAIL rst_head got=%0d exp=0", head_ptr); end
        checks++; if (count !== 7'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rst_empty_full got=%b%b exp=10", empty, full); end
    endtask

    task automatic test_fill();
        do_reset();
        alloc_valid = 1;
        for (int i = 0; i < 64; i++) begin
            #1;
            checks++; if (alloc_ptr !== 6'(i) || alloc_ready !== 1'b1) begin errors++; $display("FAIL fill_ptr[%0d] got=%0d rdy=%b exp=%0d rdy=1", i, alloc_ptr, alloc_ready, i); end
            step();
        end
        #1;
        checks++; if (full !== 1'b1 || alloc_ready !== 1'b0) begin errors++; $display("FAIL fill_full got full=%b rdy=%b exp full=1 rdy=0", full, alloc_ready); end
        checks++; if (count !== 7'd64) begin errors++; $display("FAIL fill_count got=%0d exp=64", count); end
        // flush at the youngest entry of a full queue removes nothing
        flush_valid = 1; flush_ptr = 6'd63; step(); flush_valid = 0; alloc_valid = 0; #1;
        checks++; if (count !== 7'd64 || alloc_ptr !== 6'd0) begin errors++; $display("FAIL full_flush got cnt=%0d ptr=%0d exp cnt=64 ptr=0", count, alloc_ptr); end
        checks++; if (dut.valid !== {64{1'b1}}) begin errors++; $display("FAIL full_flush_valid got=%h exp=all ones", dut.valid); end
        retire_valid = 1; #1;
        checks++; if (retire_ready !== 1'b0) begin errors++; $display("FAIL fill_retire_unissued got=%b exp=0", retire_ready); end
        step(); retire_valid = 0; #1;
        checks++; if (count !== 7'd64) begin errors++; $display("FAIL fill_retire_stall got=%0d exp=64", count); end
        set_ready(6'd0);
        issue_ready = 1; #1;
        checks++; if (issue_valid !== 1'b1 || issue_ptr !== 6'd0) begin errors++; $display("FAIL fill_issue0 got v=%b p=%0d exp v=1 p=0", issue_valid, issue_ptr); end
        step(); issue_ready = 0;
        retire_valid = 1; alloc_valid = 1; #1;
        checks++; if (retire_ready !== 1'b1 || alloc_ready !== 1'b0) begin errors++; $display("FAIL full_retire_alloc got ret=%b al=%b exp ret=1 al=0", retire_ready, alloc_ready); end
        step(); retire_valid = 0; alloc_valid = 0; #1;
        checks++; if (count !== 7'd63 || head_ptr !== 6'd1 || alloc_ready !== 1'b1) begin errors++; $display("FAIL full_retire_after got cnt=%0d head=%0d al=%b exp cnt=63 head=1 al=1", count, head_ptr, alloc_ready); end
    endtask

    task automatic test_wrap_order();
        logic [5:0] set_ord [8];
        logic [5:0] exp_ord [8];
        set_ord = '{6'd3, 6'd2, 6'd1, 6'd0, 6'd63, 6'd62, 6'd61, 6'd60};
        exp_ord = '{6'd60, 6'd61, 6'd62, 6'd63, 6'd0, 6'd1, 6'd2, 6'd3};
        do_reset();
        advance_head(60);
        checks++; if (head_ptr !== 6'd60 || empty !== 1'b1) begin errors++; $display("FAIL wrap_setup got head=%0d empty=%b exp head=60 empty=1", head_ptr, empty); end
        alloc_n(8);
        for (int i = 0; i < 8; i++) set_ready(set_ord[i]);
        issue_ready = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (issue_valid !== 1'b1 || issue_ptr !== exp_ord[i]) begin errors++; $display("FAIL wrap_order[%0d] got v=%b p=%0d exp v=1 p=%0d", i, issue_valid, issue_ptr, exp_ord[i]); end
            step();
        end
        issue_ready = 0; #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wrap_drained got=%b exp=0", issue_valid); end
        retire_valid = 1;
        for (int i = 0; i < 8; i++) step();
        retire_valid = 0; #1;
        checks++; if (count !== 7'd0 || head_ptr !== 6'd4) begin errors++; $display("FAIL wrap_retire got cnt=%0d head=%0d exp cnt=0 head=4", count, head_ptr); end
    endtask

    task automatic test_ready_order();
        do_reset();
        alloc_n(10);
        set_ready(6'd20);
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL rdy_invalid_slot got=%b exp=0", issue_valid); end
        set_ready(6'd7);
        checks++; if (issue_valid !== 1'b1 || issue_ptr !== 6'd7) begin errors++; $display("FAIL rdy_first got v=%b p=%0d exp v=1 p=7", issue_valid, issue_ptr); end
        rdy_set_valid = 1; rdy_set_ptr = 6'd2; issue_ready = 1; step(); rdy_set_valid = 0; #1;
        checks++; if (issue_valid !== 1'b1 || issue_ptr !== 6'd2) begin errors++; $display("FAIL rdy_second got v=%b p=%0d exp v=1 p=2", issue_valid, issue_ptr); end
        checks++; if (retire_ready !== 1'b0) begin errors++; $display("FAIL rdy_head_unissued got=%b exp=0", retire_ready); end
        step(); issue_ready = 0; #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL rdy_none_left got=%b exp=0", issue_valid); end
        retire_valid = 1; step(); retire_valid = 0; #1;
        checks++; if (count !== 7'd10) begin errors++; $display("FAIL rdy_retire_stall got=%0d exp=10", count); end
        set_ready(6'd0);
        issue_ready = 1; step(); issue_ready = 0; #1;
        checks++; if (retire_ready !== 1'b1) begin errors++; $display("FAIL rdy_retire_after_issue got=%b exp=1", retire_ready); end
    endtask

    task automatic test_flush_plain();
        do_reset();
        alloc_n(10);
        set_ready(6'd1);
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL fl_pre_issue got=%b exp=1", issue_valid); end
        flush_valid = 1; flush_ptr = 6'd4; alloc_valid = 1; #1;
        checks++; if (issue_valid !== 1'b0 || alloc_ready !== 1'b0) begin errors++; $display("FAIL fl_block got iv=%b ar=%b exp 0 0", issue_valid, alloc_ready); end
        step(); flush_valid = 0; alloc_valid = 0; #1;
        checks++; if (dut.valid !== 64'h1F) begin errors++; $display("FAIL fl_valid got=%h exp=1f", dut.valid); end
        checks++; if (alloc_ptr !== 6'd5 || count !== 7'd5) begin errors++; $display("FAIL fl_ptr_cnt got p=%0d c=%0d exp p=5 c=5", alloc_ptr, count); end
        checks++; if (issue_valid !== 1'b1 || issue_ptr !== 6'd1) begin errors++; $display("FAIL fl_survivor got v=%b p=%0d exp v=1 p=1", issue_valid, issue_ptr); end
    endtask

    task automatic test_flush_wrap();
        do_reset();
        advance_head(50);
        alloc_n(20);
        checks++; if (count !== 7'd20 || alloc_ptr !== 6'd6 || head_ptr !== 6'd50) begin errors++; $display("FAIL flw_setup got c=%0d in=%0d h=%0d exp 20 6 50", count, alloc_ptr, head_ptr); end
        flush_valid = 1; flush_ptr = 6'd60; step(); flush_valid = 0; #1;
        checks++; if (count !== 7'd11 || alloc_ptr !== 6'd61) begin errors++; $display("FAIL flw_cnt got c=%0d in=%0d exp c=11 in=61", count, alloc_ptr); end
        checks++; if (dut.valid !== 64'h1FFC_0000_0000_0000) begin errors++; $display("FAIL flw_valid got=%h exp=1ffc000000000000", dut.valid); end
        alloc_n(9);
        set_ready(6'd50);
        issue_ready = 1; #1;
        checks++; if (issue_ptr !== 6'd50) begin errors++; $display("FAIL flw_issue50 got=%0d exp=50", issue_ptr); end
        step(); issue_ready = 0;
        flush_valid = 1; flush_ptr = 6'd60; retire_valid = 1; #1;
        checks++; if (retire_ready !== 1'b1) begin errors++; $display("FAIL flw_retire_ready got=%b exp=1", retire_ready); end
        step(); flush_valid = 0; retire_valid = 0; #1;
        checks++; if (count !== 7'd10 || head_ptr !== 6'd51 || alloc_ptr !== 6'd61) begin errors++; $display("FAIL flw_retire got c=%0d h=%0d in=%0d exp 10 51 61", count, head_ptr, alloc_ptr); end
        checks++; if (dut.valid !== 64'h1FF8_0000_0000_0000) begin errors++; $display("FAIL flw_retire_valid got=%h exp=1ff8000000000000", dut.valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        alloc_n(30);
        set_ready(6'd3);
        issue_ready = 1; step(); issue_ready = 0;
        set_ready(6'd4);
        checks++; if (count !== 7'd30 || issue_valid !== 1'b1) begin errors++; $display("FAIL rm_setup got c=%0d iv=%b exp 30 1", count, issue_valid); end
        rst_n = 0; step(); rst_n = 1; #1;
        checks++; if (count !== 7'd0 || empty !== 1'b1 || issue_valid !== 1'b0) begin errors++; $display("FAIL rm_state got c=%0d e=%b iv=%b exp 0 1 0", count, empty, issue_valid); end
        checks++; if ((dut.valid | dut.ready | dut.issued) !== 64'h0) begin errors++; $display("FAIL rm_vectors got=%h exp=0", dut.valid | dut.ready | dut.issued); end
        checks++; if (alloc_ptr !== 6'd0 || head_ptr !== 6'd0) begin errors++; $display("FAIL rm_ptrs got in=%0d h=%0d exp 0 0", alloc_ptr, head_ptr); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        idle();
        rst_n = 0;
        step(); step();
        test_reset();
        test_fill();
        test_wrap_order();
        test_ready_order();
        test_flush_plain();
        test_flush_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
